// File: rtl/mem_rw_pipe.sv
// ----------------------------------------------------------------------------
// mem_rw_pipe
//   Single-port synchronous word memory. Requests arrive on a valid/ready
//   channel, and read responses leave in order on a second valid/ready
//   channel. Writes use byte enables. Read data passes through RD_LAT register
//   stages and then a first-word-fall-through response FIFO. New requests are
//   accepted only while a FIFO slot is guaranteed for every read in flight.
//   Reads of addresses >= DEPTH return zero data with the error flag set.
//   Writes to those addresses are dropped silently.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_req_valid    request present
//   o_req_ready    request can be accepted this cycle
//   i_req_rw       0 = read, 1 = write
//   i_req_addr     word address
//   i_req_wdata    write data
//   i_req_wstrb    byte enables, bit k covers byte k
//   o_resp_valid   read response present
//   i_resp_ready   consumer takes the response
//   o_resp_data    read data (zero when no response is present)
//   o_resp_err     response belongs to an out-of-range address
//   o_occupancy    reads in flight plus responses queued
// ----------------------------------------------------------------------------
module mem_rw_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_req_rw,
  input  logic [ADDR_W-1:0]               i_req_addr,
  input  logic [DATA_W-1:0]               i_req_wdata,
  input  logic [DATA_W/8-1:0]             i_req_wstrb,
  output logic                            o_resp_valid,
  input  logic                            i_resp_ready,
  output logic [DATA_W-1:0]               o_resp_data,
  output logic                            o_resp_err,
  output logic [$clog2(RESP_DEPTH+1)-1:0] o_occupancy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OCC_W  = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

  // Elaboration-time parameter legality check.
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DEPTH < 1 || DEPTH > (1 << ADDR_W) ||
      RD_LAT < 1 || RD_LAT > 4 || RESP_DEPTH < RD_LAT) begin : g_paramCheck
    $fatal(1, "mem_rw_pipe: illegal parameter combination");
  end

  // Storage and state
  logic [DATA_W-1:0] mem [DEPTH];

  logic                  enable_q;
  logic [OCC_W-1:0]      occupancy_q, occupancy_d;

  logic [RD_LAT-1:0]     pipeValid_q;
  logic [RD_LAT-1:0]     pipeErr_q;
  logic [DATA_W-1:0]     pipeData_q [RD_LAT];

  logic [DATA_W-1:0]     fifoData_q [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifoErr_q;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]      fifoCount_q, fifoCount_d;

  logic addrInRange;
  logic reqAccept;
  logic readAccept;
  logic writeAccept;
  logic fifoPush;
  logic respPop;

  // Ready depends only on registered state. Counting every in-flight read
  // against the FIFO size guarantees a free slot for each read, so the
  // pipeline never has to stall and no response can be lost.
  assign o_req_ready = enable_q & (occupancy_q < OCC_MAX);
  assign addrInRange = {1'b0, i_req_addr} < (ADDR_W + 1)'(DEPTH);
  assign reqAccept   = i_req_valid & o_req_ready;
  assign readAccept  = reqAccept & ~i_req_rw;
  assign writeAccept = reqAccept & i_req_rw;
  assign fifoPush    = pipeValid_q[RD_LAT-1];

  assign o_resp_valid = (fifoCount_q != '0);
  assign respPop      = o_resp_valid & i_resp_ready;
  assign o_resp_data  = o_resp_valid ? fifoData_q[rdPtr_q] : '0;
  assign o_resp_err   = o_resp_valid & fifoErr_q[rdPtr_q];
  assign o_occupancy  = occupancy_q;

  // Memory array has no reset, so its contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (writeAccept && addrInRange) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (i_req_wstrb[k]) begin
          mem[i_req_addr][k*8 +: 8] <= i_req_wdata[k*8 +: 8];
        end
      end
    end
  end

  // Read pipeline. Stage 0 samples the array on the accept edge, so a read
  // that follows a write to the same address sees the new contents.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pipeValid_q <= '0;
      pipeErr_q   <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pipeData_q[s] <= '0;
      end
    end else begin
      pipeValid_q[0] <= readAccept;
      pipeErr_q[0]   <= readAccept & ~addrInRange;
      pipeData_q[0]  <= (readAccept && addrInRange) ? mem[i_req_addr] : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        pipeValid_q[s] <= pipeValid_q[s-1];
        pipeErr_q[s]   <= pipeErr_q[s-1];
        pipeData_q[s]  <= pipeData_q[s-1];
      end
    end
  end

  // FIFO payload storage. The output is gated by o_resp_valid, so the
  // payload does not need a reset.
  always_ff @(posedge i_clk) begin
    if (fifoPush) begin
      fifoData_q[wrPtr_q] <= pipeData_q[RD_LAT-1];
      fifoErr_q[wrPtr_q]  <= pipeErr_q[RD_LAT-1];
    end
  end

  // Next-state logic for the FIFO pointers, FIFO count and occupancy.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fifoCount_d = fifoCount_q;
    occupancy_d = occupancy_q;

    if (fifoPush) begin
      wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + 1'b1;
    end
    if (respPop) begin
      rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + 1'b1;
    end

    case ({fifoPush, respPop})
      2'b10:   fifoCount_d = fifoCount_q + 1'b1;
      2'b01:   fifoCount_d = fifoCount_q - 1'b1;
      default: fifoCount_d = fifoCount_q;
    endcase

    case ({readAccept, respPop})
      2'b10:   occupancy_d = occupancy_q + 1'b1;
      2'b01:   occupancy_d = occupancy_q - 1'b1;
      default: occupancy_d = occupancy_q;
    endcase
  end

  // Control registers. enable_q keeps ready low until the first edge
  // after reset release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      enable_q    <= 1'b0;
      occupancy_q <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      enable_q    <= 1'b1;
      occupancy_q <= occupancy_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoCount_q <= fifoCount_d;
    end
  end

  // Snapshot of a stalled request. Only the simulation checks below use it.
  logic              stall_q;
  logic              stallRw_q;
  logic [ADDR_W-1:0] stallAddr_q;
  logic [DATA_W-1:0] stallWdata_q;
  logic [STRB_W-1:0] stallWstrb_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_q      <= 1'b0;
      stallRw_q    <= 1'b0;
      stallAddr_q  <= '0;
      stallWdata_q <= '0;
      stallWstrb_q <= '0;
    end else begin
      stall_q      <= i_req_valid & ~o_req_ready;
      stallRw_q    <= i_req_rw;
      stallAddr_q  <= i_req_addr;
      stallWdata_q <= i_req_wdata;
      stallWstrb_q <= i_req_wstrb;
    end
  end

  // Simulation checks: the occupancy bound, and a stalled request staying
  // unchanged until it is accepted.
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (occupancy_q <= OCC_MAX)
        else $error("mem_rw_pipe: occupancy %0d exceeds %0d", occupancy_q, RESP_DEPTH);
      if (stall_q) begin
        assert (i_req_valid && i_req_rw == stallRw_q && i_req_addr == stallAddr_q &&
                i_req_wdata == stallWdata_q && i_req_wstrb == stallWstrb_q)
          else $error("mem_rw_pipe: request changed while stalled");
      end
    end
  end

endmodule
